// File: rtl/rc4_pkg.sv
// Shared constants and state encoding for the RC4 sequencer.
// States are plain localparams so older tools can consume them too.
package rc4_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SBOX_DEPTH - 1);

    typedef logic [3:0] state_t;

    localparam state_t IDLE   = 4'd0;
    localparam state_t INIT   = 4'd1;
    localparam state_t KSA_A  = 4'd2;
    localparam state_t KSA_B  = 4'd3;
    localparam state_t KSA_C  = 4'd4;
    localparam state_t PRGA_A = 4'd5;
    localparam state_t PRGA_B = 4'd6;
    localparam state_t PRGA_C = 4'd7;
    localparam state_t PRGA_D = 4'd8;
    localparam state_t OUT    = 4'd9;

endpackage

// File: rtl/rc4_key_sel.sv
// Latched key register and the key-byte index that cycles over key_len.
// The key is captured once per start so the input may change afterwards.
module rc4_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_MAX_BYTES = 16,
    parameter int KLEN_W        = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic                       adv_i,
    input  logic [KEY_MAX_BYTES*8-1:0] key_i,
    input  logic [KLEN_W-1:0]          klen_i,
    output logic [DATA_W-1:0]          key_byte_o
);

    logic [KEY_MAX_BYTES*8-1:0] key_q;
    logic [KLEN_W-1:0]          klen_q;
    logic [KLEN_W-1:0]          kidx_q;
    logic [KLEN_W-1:0]          kidx_d;
    logic                       last;

    assign last = (kidx_q == klen_q - KLEN_W'(1));

    always_comb begin
        kidx_d = kidx_q;
        if (load_i) begin
            kidx_d = '0;
        end else if (adv_i) begin
            kidx_d = last ? '0 : kidx_q + KLEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            klen_q <= '0;
            kidx_q <= '0;
        end else begin
            kidx_q <= kidx_d;
            if (load_i) begin
                key_q  <= key_i;
                klen_q <= klen_i;
            end
        end
    end

    assign key_byte_o = DATA_W'(key_q >> {kidx_q, 3'b000});

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 sequencer: identity init, KSA, then PRGA over a 3-port S-box RAM.
// Ports 2 and 3 are never written together; each swap spans two cycles.
module rc4_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_MAX_BYTES = 16,
    parameter int KLEN_W        = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [KEY_MAX_BYTES*8-1:0] key,
    input  logic [KLEN_W-1:0]          key_len,
    output logic                       busy,
    output logic [DATA_W-1:0]          ks_data,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic [ADDR_W-1:0]          ram_raddr_1,
    input  logic [DATA_W-1:0]          ram_rdata_1,
    output logic                       ram_wen_2,
    output logic [ADDR_W-1:0]          ram_waddr_2,
    output logic [DATA_W-1:0]          ram_wdata_2,
    output logic                       ram_wen_3,
    output logic [ADDR_W-1:0]          ram_addr_3,
    output logic [DATA_W-1:0]          ram_wdata_3,
    input  logic [DATA_W-1:0]          ram_rdata_3
);

    localparam logic [KLEN_W-1:0] KMAX = KLEN_W'(KEY_MAX_BYTES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [DATA_W-1:0]   si_q, si_d;
    logic [DATA_W-1:0]   sj_q, sj_d;
    logic [DATA_W-1:0]   ks_data_q, ks_data_d;
    logic                ks_valid_q, ks_valid_d;
    logic                pend_q, pend_d;
    logic                load;
    logic                adv;
    logic                klen_ok;
    logic [DATA_W-1:0]   key_byte;

    rc4_key_sel #(
        .KEY_MAX_BYTES(KEY_MAX_BYTES),
        .KLEN_W       (KLEN_W)
    ) u_key_sel (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .adv_i     (adv),
        .key_i     (key),
        .klen_i    (key_len),
        .key_byte_o(key_byte)
    );

    assign klen_ok = (key_len != '0) && (key_len <= KMAX);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        ks_data_d   = ks_data_q;
        ks_valid_d  = ks_valid_q;
        pend_d      = pend_q;
        load        = 1'b0;
        adv         = 1'b0;
        ram_raddr_1 = '0;
        ram_wen_2   = 1'b0;
        ram_waddr_2 = '0;
        ram_wdata_2 = '0;
        ram_wen_3   = 1'b0;
        ram_addr_3  = '0;
        ram_wdata_3 = '0;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (start && klen_ok) begin
                    load    = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                ram_wen_2   = 1'b1;
                ram_waddr_2 = i_q;
                ram_wdata_2 = i_q;
                i_d         = i_q + 8'd1;
                if (i_q == LAST_IDX) state_d = KSA_A;
                if (stop) state_d = IDLE;
            end
            KSA_A: begin
                ram_raddr_1 = i_q;
                si_d        = ram_rdata_1;
                j_d         = j_q + ram_rdata_1 + key_byte;
                state_d     = stop ? IDLE : KSA_B;
            end
            KSA_B: begin
                ram_addr_3  = j_q;
                ram_wen_2   = 1'b1;
                ram_waddr_2 = i_q;
                ram_wdata_2 = ram_rdata_3;
                state_d     = stop ? IDLE : KSA_C;
            end
            KSA_C: begin
                ram_wen_3   = 1'b1;
                ram_addr_3  = j_q;
                ram_wdata_3 = si_q;
                i_d         = i_q + 8'd1;
                adv         = 1'b1;
                if (i_q == LAST_IDX) begin
                    j_d     = '0;
                    state_d = PRGA_A;
                end else begin
                    state_d = KSA_A;
                end
                if (stop) state_d = IDLE;
            end
            PRGA_A: begin
                if (stop || pend_q) begin
                    state_d = IDLE;
                end else begin
                    ram_raddr_1 = i_q + 8'd1;
                    i_d         = i_q + 8'd1;
                    j_d         = j_q + ram_rdata_1;
                    si_d        = ram_rdata_1;
                    state_d     = PRGA_B;
                end
            end
            PRGA_B: begin
                ram_addr_3  = j_q;
                ram_wen_2   = 1'b1;
                ram_waddr_2 = i_q;
                ram_wdata_2 = ram_rdata_3;
                sj_d        = ram_rdata_3;
                pend_d      = pend_q | stop;
                state_d     = PRGA_C;
            end
            PRGA_C: begin
                ram_wen_3   = 1'b1;
                ram_addr_3  = j_q;
                ram_wdata_3 = si_q;
                pend_d      = pend_q | stop;
                state_d     = PRGA_D;
            end
            PRGA_D: begin
                ram_raddr_1 = si_q + sj_q;
                ks_data_d   = ram_rdata_1;
                ks_valid_d  = 1'b1;
                pend_d      = pend_q | stop;
                state_d     = OUT;
            end
            OUT: begin
                // An abort discards the held byte even if it is being accepted.
                if (stop || pend_q) begin
                    ks_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ks_ready) begin
                    ks_valid_d = 1'b0;
                    state_d    = PRGA_A;
                end
            end
            default: begin
                ks_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
            pend_q     <= pend_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign ks_data  = ks_data_q;
    assign ks_valid = ks_valid_q;

endmodule

// File: tb/tb_rc4_ctrl.sv
// Bench for rc4_ctrl: behavioural S-box RAM plus a queue of known vectors.
module tb_rc4_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   key_len = '0;
    logic         busy;
    logic [7:0]   ks_data;
    logic         ks_valid;
    logic         ks_ready = 1'b0;
    logic [7:0]   ram_raddr_1;
    logic [7:0]   ram_rdata_1;
    logic         ram_wen_2;
    logic [7:0]   ram_waddr_2;
    logic [7:0]   ram_wdata_2;
    logic         ram_wen_3;
    logic [7:0]   ram_addr_3;
    logic [7:0]   ram_wdata_3;
    logic [7:0]   ram_rdata_3;

    int assertions = 0;
    int failures = 0;
    int excl_viol = 0;
    int wr_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mem[256];

    localparam logic [127:0] K_KEY  = 128'h79654B;
    localparam logic [127:0] K_WIKI = 128'h696B6957;
    localparam logic [127:0] K_SEC  = 128'h746572636553;

    logic [7:0] v_key[10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                              8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0] v_wiki[6] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    logic [7:0] v_sec[8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05,
                              8'h3C, 8'hA8, 8'h7B, 8'h59};

    always #5 clk = ~clk;

    rc4_ctrl #(.KEY_MAX_BYTES(16), .KLEN_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .key        (key),
        .key_len    (key_len),
        .busy       (busy),
        .ks_data    (ks_data),
        .ks_valid   (ks_valid),
        .ks_ready   (ks_ready),
        .ram_raddr_1(ram_raddr_1),
        .ram_rdata_1(ram_rdata_1),
        .ram_wen_2  (ram_wen_2),
        .ram_waddr_2(ram_waddr_2),
        .ram_wdata_2(ram_wdata_2),
        .ram_wen_3  (ram_wen_3),
        .ram_addr_3 (ram_addr_3),
        .ram_wdata_3(ram_wdata_3),
        .ram_rdata_3(ram_rdata_3)
    );

    // RAM resets to a non-identity pattern so a skipped INIT shows up.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ 8'hA5;
        end else if (ram_wen_2) begin
            mem[ram_waddr_2] <= ram_wdata_2;
        end else if (ram_wen_3) begin
            mem[ram_addr_3] <= ram_wdata_3;
        end
    end

    assign ram_rdata_1 = mem[ram_raddr_1];
    assign ram_rdata_3 = mem[ram_addr_3];

    always @(negedge clk) begin
        if (ram_wen_2 && ram_wen_3) excl_viol++;
        if (ram_wen_2 || ram_wen_3) wr_cnt++;
    end

    task automatic start_key(input logic [127:0] k, input logic [4:0] n);
        @(negedge clk);
        key = k;
        key_len = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (ks_valid !== 1'b1 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic collect(input string nm, input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        int last = -1;
        bit stalled = 0;
        logic [7:0] held = '0;
        logic [7:0] e;
        while (got < n && cyc < n * 40 + 50) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                assertions++;
                if (ks_valid !== 1'b1 || ks_data !== held) begin
                    failures++;
                    $display("FAIL %s stall: valid=%b data=%h want 1/%h",
                             nm, ks_valid, ks_data, held);
                end
            end
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 0;
            if (ks_valid === 1'b1) begin
                if (ks_ready) begin
                    e = exp_q.pop_front();
                    assertions++;
                    if (ks_data !== e) begin
                        failures++;
                        $display("FAIL %s byte%0d: got %h want %h",
                                 nm, got, ks_data, e);
                    end
                    if (!rnd && last >= 0) begin
                        assertions++;
                        if (cyc - last != 5) begin
                            failures++;
                            $display("FAIL %s rate: got %0d want 5",
                                     nm, cyc - last);
                        end
                    end
                    last = cyc;
                    got++;
                end else begin
                    stalled = 1;
                    held = ks_data;
                end
            end
        end
        assertions++;
        if (got != n) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", nm, got, n);
        end
    endtask

    task automatic do_stop(input string nm);
        int c = 0;
        @(negedge clk);
        ks_ready = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        while (busy !== 1'b0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        assertions++;
        if (busy !== 1'b0 || ks_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s stop: busy=%b valid=%b want 0/0",
                     nm, busy, ks_valid);
        end
    endtask

    task automatic test_reset();
        #3;
        assertions++;
        if ({busy, ks_valid, ram_wen_2, ram_wen_3} !== 4'b0 ||
            ks_data !== 8'h0 || ram_raddr_1 !== 8'h0 ||
            ram_waddr_2 !== 8'h0 || ram_wdata_2 !== 8'h0 ||
            ram_addr_3 !== 8'h0 || ram_wdata_3 !== 8'h0) begin
            failures++;
            $display("FAIL reset: b=%b v=%b w2=%b w3=%b d=%h want zeros",
                     busy, ks_valid, ram_wen_2, ram_wen_3, ks_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_key();
        int cnt;
        exp_q.delete();
        foreach (v_key[k]) exp_q.push_back(v_key[k]);
        start_key(K_KEY, 5'd3);
        assertions++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL key busy: got %b want 1", busy);
        end
        wait_valid(1200, cnt);
        assertions++;
        if (cnt != 1028) begin
            failures++;
            $display("FAIL key latency: got %0d want 1028", cnt);
        end
        collect("key", 10, 0);
        do_stop("key");
    endtask

    task automatic test_wiki();
        int cnt;
        exp_q.delete();
        foreach (v_wiki[k]) exp_q.push_back(v_wiki[k]);
        start_key(K_WIKI, 5'd4);
        wait_valid(1200, cnt);
        collect("wiki", 6, 0);
        do_stop("wiki");
    endtask

    task automatic test_secret();
        int cnt;
        exp_q.delete();
        foreach (v_sec[k]) exp_q.push_back(v_sec[k]);
        start_key(K_SEC, 5'd6);
        wait_valid(1200, cnt);
        collect("secret", 8, 1);
        do_stop("secret");
    endtask

    task automatic test_bad_len();
        int w0;
        int seen;
        logic [4:0] lens[2] = '{5'd0, 5'd17};
        foreach (lens[n]) begin
            w0 = wr_cnt;
            seen = 0;
            start_key(K_KEY, lens[n]);
            repeat (20) begin
                @(negedge clk);
                if (busy !== 1'b0) seen++;
            end
            assertions++;
            if (seen != 0 || wr_cnt != w0) begin
                failures++;
                $display("FAIL badlen%0d: busy_cycles=%0d writes=%0d want 0/0",
                         lens[n], seen, wr_cnt - w0);
            end
        end
    endtask

    task automatic test_start_in_ksa();
        int cnt;
        exp_q.delete();
        foreach (v_key[k]) exp_q.push_back(v_key[k]);
        start_key(K_KEY, 5'd3);
        repeat (598) @(negedge clk);
        start_key(K_WIKI, 5'd4);
        assertions++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ksa_start busy: got %b want 1", busy);
        end
        wait_valid(1200, cnt);
        assertions++;
        if (cnt != 428) begin
            failures++;
            $display("FAIL ksa_start latency: got %0d want 428", cnt);
        end
        collect("ksa_start", 10, 0);
        do_stop("ksa_start");
    endtask

    task automatic test_stop_ksa();
        int cnt;
        start_key(K_WIKI, 5'd4);
        repeat (498) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ksa_stop busy: got %b want 0", busy);
        end
        exp_q.delete();
        foreach (v_key[k]) exp_q.push_back(v_key[k]);
        start_key(K_KEY, 5'd3);
        wait_valid(1200, cnt);
        assertions++;
        if (cnt != 1028) begin
            failures++;
            $display("FAIL ksa_stop latency: got %0d want 1028", cnt);
        end
        collect("ksa_stop", 10, 0);
        do_stop("ksa_stop");
    endtask

    task automatic test_rst_out();
        int cnt;
        ks_ready = 1'b0;
        start_key(K_WIKI, 5'd4);
        wait_valid(1200, cnt);
        assertions++;
        if (ks_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_out pre: valid=%b want 1", ks_valid);
        end
        #2 rst = 1'b1;
        #1;
        assertions++;
        if ({busy, ks_valid, ram_wen_2, ram_wen_3} !== 4'b0) begin
            failures++;
            $display("FAIL rst_out async: b=%b v=%b w2=%b w3=%b want 0",
                     busy, ks_valid, ram_wen_2, ram_wen_3);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        foreach (v_wiki[k]) exp_q.push_back(v_wiki[k]);
        start_key(K_WIKI, 5'd4);
        wait_valid(1200, cnt);
        collect("rst_out", 6, 1);
        do_stop("rst_out");
    endtask

    initial begin
        test_reset();
        test_key();
        test_wiki();
        test_secret();
        test_bad_len();
        test_start_in_ksa();
        test_stop_ksa();
        test_rst_out();
        assertions++;
        if (excl_viol != 0) begin
            failures++;
            $display("FAIL wen_excl: got %0d dual-write cycles want 0",
                     excl_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule

// File: doc/rc4_ctrl.md
Name: rc4_ctrl

Overview:
- Sequencer that drives the three-port 256x8 RC4 S-box RAM: read port 1, write port 2, read/write port 3.
- Runs the key-scheduling algorithm (identity init + KSA), then the PRGA.
- Delivers keystream bytes over a valid/ready handshake to the cipher XOR stage.
- Self-contained: it rebuilds S from scratch on every start and never relies on the RAM's own reset contents.

Parameters:
KEY_MAX_BYTES, 16, maximum key length in bytes
KLEN_W, 5, width of key_len; must hold the value KEY_MAX_BYTES

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to load a key and begin; honoured only in IDLE
stop  in  1  abort to IDLE
key  in  KEY_MAX_BYTES*8  key bytes; byte n is key[8n+7:8n]; sampled when start is accepted
key_len  in  KLEN_W  key length in bytes, valid range 1..KEY_MAX_BYTES; sampled with key
busy  out  1  high in every state except IDLE
ks_data  out  8  keystream byte
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accepts
ram_raddr_1  out  8  RAM port 1 read address
ram_rdata_1  in  8  RAM port 1 read data, combinational from ram_raddr_1
ram_wen_2  out  1  RAM port 2 write enable
ram_waddr_2  out  8  RAM port 2 write address
ram_wdata_2  out  8  RAM port 2 write data
ram_wen_3  out  1  RAM port 3 write enable
ram_addr_3  out  8  RAM port 3 read/write address
ram_wdata_3  out  8  RAM port 3 write data
ram_rdata_3  in  8  RAM port 3 read data, combinational from ram_addr_3

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE; i, j, kidx, si, ks_data all 0.
  - busy=0, ks_valid=0, ram_wen_2=0, ram_wen_3=0; all RAM addresses and write data are 0.
  - Integration ties the RAM's rst_n to ~rst.
- RAM write rule: the RAM gives wen_2 priority over wen_3, so this block never asserts ram_wen_2 and ram_wen_3 in the same cycle. Each swap therefore takes two write cycles.
- IDLE:
  - Leaves only when start=1 and key_len is in 1..KEY_MAX_BYTES; it then latches key and key_len, and clears i, j and kidx.
  - start with key_len=0 or key_len>KEY_MAX_BYTES is ignored.
  - start outside IDLE is ignored.
- INIT: one cycle per index. Write S[i]=i via port 2, then i++. After the write at i=255, i wraps to 0 and the state goes to KSA_A. Duration 256 cycles.
- KSA, 3 cycles per i:
  - KSA_A: ram_raddr_1=i. Set si<=rdata_1 and j<=j+rdata_1+key[kidx] (mod 256).
  - KSA_B: ram_addr_3=j. Write S[i]<=rdata_3 via port 2.
  - KSA_C: write S[j]<=si via port 3. Then i++. kidx increments and wraps to 0 after key_len-1.
  - i==j is legal: the result is that S is unchanged.
  - After KSA_C at i=255: i<=0, j<=0, state goes to PRGA_A. Duration 768 cycles.
- PRGA, 4 cycles per byte:
  - PRGA_A: i<=i+1; j<=j+S[i+1] using port 1 at address i+1; latch si.
  - PRGA_B: read S[j] on port 3; write S[i]<=S[j] on port 2; latch sj.
  - PRGA_C: write S[j]<=si on port 3.
  - PRGA_D: ram_raddr_1=si+sj (mod 256); ks_data<=rdata_1; ks_valid<=1; state goes to OUT.
  - OUT: hold ks_data and ks_valid until ks_valid&ks_ready. On that edge ks_valid<=0 and the state goes to PRGA_A.
- Latency:
  - ks_valid first rises on the 1028th rising edge after the edge that accepts start.
  - With ks_ready held high, one byte is delivered every 5 cycles.
- Ordering: ks_data is stable while ks_valid=1 and ks_ready=0. A byte is never dropped or duplicated.
- stop:
  - In INIT or KSA: immediate return to IDLE; S is left partially built and is rebuilt on the next start.
  - In PRGA_B, PRGA_C or PRGA_D: deferred until the swap completes, i.e. honoured at the next PRGA_A or OUT.
  - In PRGA_A or OUT: IDLE on the next edge with ks_valid=0; the pending byte is discarded.
- Counters: i, j, kidx wrap modulo their range with no overflow flag. All address arithmetic is 8-bit modulo 256.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum {IDLE, INIT, KSA_A, KSA_B, KSA_C, PRGA_A, PRGA_B, PRGA_C, PRGA_D, OUT};
  - SBOX_DEPTH=256, ADDR_W=8, DATA_W=8.
- One sub-module, rc4_key_sel: holds the latched key register and the kidx wrap counter, and outputs the current key byte.

Test Plan:
- Key "Key" (4B 65 79), key_len=3, ks_ready=1 -> first 10 bytes EB 9F 77 81 B7 34 CA 72 A7 19; first ks_valid on edge 1028 after start.
- Key "Wiki", key_len=4 -> 60 44 DB 6D 41 B7. Check ram_wen_2&ram_wen_3 is never 1 in the same cycle (assertion).
- Key "Secret", key_len=6, ks_ready toggled with a random pattern -> 04 D4 6B 05 3C A8 7B 59 in order; ks_data stable while stalled.
- start with key_len=0 -> busy stays 0 and no RAM writes occur. start during KSA -> ignored; output still matches vector.
- stop mid-KSA (cycle 500), then a new start with key "Key" -> stream EB 9F 77... exactly as in scenario 1.
- rst asserted mid-PRGA during OUT -> ks_valid, busy and both write enables go to 0 asynchronously; a subsequent start with "Wiki" -> 60 44 DB...
